// File: rtl/stopwatch_run_ctrl_if.sv
// Button levels into, and run/adjust controls out of, the stopwatch run controller.
interface stopwatch_run_ctrl_if #(
  parameter int FIELD_W = 1
);
  logic               pause_button;
  logic               adjust_button;
  logic               select_button;
  logic [1:0]         state;
  logic               enable_count;
  logic               enable_pause;
  logic               enable_adjust;
  logic [FIELD_W-1:0] adj_field;
  logic               adj_inc;
  logic               clear_pulse;
  logic               blink;

  modport master (
    output pause_button, adjust_button, select_button,
    input  state, enable_count, enable_pause, enable_adjust,
    input  adj_field, adj_inc, clear_pulse, blink
  );

  modport slave (
    input  pause_button, adjust_button, select_button,
    output state, enable_count, enable_pause, enable_adjust,
    output adj_field, adj_inc, clear_pulse, blink
  );
endinterface

// File: rtl/stopwatch_run_ctrl.sv
// Run/pause/adjust sequencer for the stopwatch: button edge detection, long-press clear,
// field select/increment and blink phase, all decided in the cycle the press is sampled.
//
// state  | meaning
// IDLE   | after reset, counter stopped, waiting for auto-start or pause press
// RUN    | counter enabled
// PAUSE  | counter held; long select hold clears it
// ADJUST | counter held; select picks a field, pause increments it, field blinks
module stopwatch_run_ctrl #(
  parameter int START_RUNNING = 1,
  parameter int NUM_FIELDS    = 2,
  parameter int FIELD_W       = $clog2(NUM_FIELDS),
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int BLINK_DIV     = 25_000_000
) (
  input logic                 clk,
  input logic                 reset,
  stopwatch_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSE  = 2'b10,
    S_ADJUST = 2'b11
  } state_t;

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // Hold counter parks at HOLD_SAT after firing so a long hold clears only once.
  localparam logic [HW-1:0]      HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]      HOLD_SAT   = HW'(HOLD_CYCLES);
  localparam logic [BW-1:0]      BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [FIELD_W-1:0] FIELD_LAST = FIELD_W'(NUM_FIELDS - 1);

  state_t             state_q;
  logic [FIELD_W-1:0] adj_field_q;
  logic               adj_inc_q;
  logic               clear_pulse_q;
  logic               blink_q;
  logic [HW-1:0]      hold_q;
  logic [BW-1:0]      blink_cnt_q;
  logic               pause_hist_q;
  logic               adjust_hist_q;
  logic               select_hist_q;

  logic pause_press;
  logic adjust_press;
  logic select_press;

  assign pause_press  = bus.pause_button  & ~pause_hist_q;
  assign adjust_press = bus.adjust_button & ~adjust_hist_q;
  assign select_press = bus.select_button & ~select_hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      adj_field_q   <= '0;
      adj_inc_q     <= 1'b0;
      clear_pulse_q <= 1'b0;
      blink_q       <= 1'b0;
      hold_q        <= '0;
      blink_cnt_q   <= '0;
      pause_hist_q  <= 1'b1;
      adjust_hist_q <= 1'b1;
      select_hist_q <= 1'b1;
    end else begin
      pause_hist_q  <= bus.pause_button;
      adjust_hist_q <= bus.adjust_button;
      select_hist_q <= bus.select_button;
      adj_inc_q     <= 1'b0;
      clear_pulse_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if ((START_RUNNING != 0) || pause_press) begin
            state_q <= S_RUN;
          end
        end

        S_RUN: begin
          if (pause_press) begin
            state_q <= S_PAUSE;
          end
        end

        S_PAUSE: begin
          if (pause_press) begin
            state_q <= S_RUN;
            hold_q  <= '0;
          end else if (adjust_press) begin
            state_q     <= S_ADJUST;
            adj_field_q <= '0;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
            hold_q      <= '0;
          end else if (bus.select_button) begin
            if (hold_q == HOLD_LAST) begin
              clear_pulse_q <= 1'b1;
              hold_q        <= HOLD_SAT;
            end else if (hold_q != HOLD_SAT) begin
              hold_q <= hold_q + 1'b1;
            end
          end else begin
            hold_q <= '0;
          end
        end

        S_ADJUST: begin
          if (adjust_press) begin
            state_q     <= S_PAUSE;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
          end else begin
            if (select_press) begin
              adj_field_q <= (adj_field_q == FIELD_LAST) ? '0 : adj_field_q + 1'b1;
            end
            if (pause_press) begin
              adj_inc_q <= 1'b1;
            end
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_q <= '0;
              blink_q     <= ~blink_q;
            end else begin
              blink_cnt_q <= blink_cnt_q + 1'b1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.state         = state_q;
  assign bus.enable_count  = (state_q == S_RUN);
  assign bus.enable_pause  = (state_q == S_PAUSE) || (state_q == S_ADJUST);
  assign bus.enable_adjust = (state_q == S_ADJUST);
  assign bus.adj_field     = adj_field_q;
  assign bus.adj_inc       = adj_inc_q;
  assign bus.clear_pulse   = clear_pulse_q;
  assign bus.blink         = blink_q;

endmodule
